fifo_byte_packer: RTL and testbench

Downstream consumer of the 8-bit byte FIFO. Pops bytes from the FIFO, packs four consecutive bytes little-endian into a 32-bit word, and presents each word on a valid/ready output port. Partial words (1-3 bytes) are emitted on an explicit flush request or after a programmable idle timeout, so trailing bytes never stall in the packer.

---
 rtl/fifo_byte_packer.sv | 90 +++++++++
 tb/tb_fifo_byte_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_packer.sv
// Pops bytes from the byte FIFO and packs them little-endian into 32-bit words
// on a valid/ready port; partial words leave on a flush request or idle timeout.
module fifo_byte_packer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_is_empty,
    output logic        fifo_read_ctrl,
    input  logic [7:0]  fifo_read_data,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0]  byte_cnt;
    logic        rd_pending;
    logic        flush_pend;
    logic [7:0]  idle_cnt;
    logic [31:0] acc;

    logic        slot_free;
    logic        partial;
    logic        flush_trig;
    logic        xfer;
    logic [2:0]  eff_cnt;
    logic [31:0] acc_next;
    logic [2:0]  cnt_next;

    assign slot_free  = ~out_valid | out_ready;
    assign partial    = (byte_cnt != 3'd0) && (byte_cnt != 3'd4);
    assign flush_trig = flush_pend | (idle_cnt == TIMEOUT_CNT);

    // A partial word only leaves once any in-flight byte has landed in the accumulator.
    assign xfer    = slot_free & ((byte_cnt == 3'd4) | (partial & flush_trig & ~rd_pending));
    assign eff_cnt = xfer ? 3'd0 : byte_cnt;

    assign fifo_read_ctrl = ~fifo_is_empty & ~rst &
                            (({1'b0, eff_cnt} + {3'b000, rd_pending}) < 4'd4);

    always_comb begin
        acc_next = xfer ? 32'd0 : acc;
        cnt_next = eff_cnt;
        if (rd_pending) begin
            acc_next[{eff_cnt[1:0], 3'b000} +: 8] = fifo_read_data;
            cnt_next = eff_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= 3'd0;
            rd_pending <= 1'b0;
            flush_pend <= 1'b0;
            idle_cnt   <= 8'd0;
            acc        <= 32'd0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_bytes  <= 3'd0;
        end else begin
            rd_pending <= fifo_read_ctrl;
            byte_cnt   <= cnt_next;
            acc        <= acc_next;

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= acc;
                out_bytes <= byte_cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A flush request arriving alongside an in-flight byte survives the transfer.
            if (xfer)
                flush_pend <= in_flush & rd_pending;
            else if (in_flush && (byte_cnt != 3'd0 || rd_pending))
                flush_pend <= 1'b1;

            if (rd_pending || xfer || byte_cnt == 3'd0)
                idle_cnt <= 8'd0;
            else if (partial && fifo_is_empty && idle_cnt != TIMEOUT_CNT)
                idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a behavioural byte FIFO feeding it and
// hand-computed expected words.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_is_empty = 1'b1;
    logic        fifo_read_ctrl;
    logic [7:0]  fifo_read_data = 8'd0;
    logic        in_flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int words = 0;
    int base;
    int word_base;
    logic pop_s = 1'b0;
    logic [7:0] fifo_q[$];

    fifo_byte_packer #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_is_empty(fifo_is_empty),
        .fifo_read_ctrl(fifo_read_ctrl),
        .fifo_read_data(fifo_read_data),
        .in_flush(in_flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_bytes(out_bytes)
    );

    always #5 clk = ~clk;

    // Strobes are sampled mid-low-phase so the FIFO model never races the DUT at the edge.
    always @(negedge clk) begin
        #2;
        pop_s = fifo_read_ctrl;
        if (!rst && out_valid && out_ready)
            words++;
    end

    always @(posedge clk) begin
        if (pop_s && fifo_q.size() > 0) begin
            fifo_read_data <= fifo_q.pop_front();
            pop_cnt++;
        end
        fifo_is_empty <= (fifo_q.size() == 0);
    end

    task automatic applyStimulus(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitValid(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        step(2);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_bytes", {29'd0, out_bytes}, 32'd0);
        checkOutput("rst_rd", {31'd0, fifo_read_ctrl}, 32'd0);
        rst = 1'b0;

        // Empty FIFO never pops
        step(10);
        checkOutput("empty_no_pop", pop_cnt, 0);

        // Single full word
        $display("[TB] full word");
        out_ready = 1'b1;
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        waitValid("w1", 40);
        checkOutput("w1_data", out_data, 32'h44332211);
        checkOutput("w1_bytes", {29'd0, out_bytes}, 32'd4);
        step(5);
        checkOutput("w1_pops", pop_cnt, 4);
        checkOutput("w1_words", words, 1);
        checkOutput("w1_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure: 9 bytes, output blocked
        $display("[TB] backpressure");
        out_ready = 1'b0;
        base = pop_cnt;
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i));
        waitValid("bp1", 40);
        checkOutput("bp1_data", out_data, 32'h04030201);
        checkOutput("bp1_bytes", {29'd0, out_bytes}, 32'd4);
        for (int i = 0; i < 20; i++) begin
            step(1);
            checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_hold_data", out_data, 32'h04030201);
        end
        checkOutput("bp_pops", pop_cnt - base, 8);
        word_base = words;
        out_ready = 1'b1;
        step(1);
        checkOutput("bp2_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp2_data", out_data, 32'h08070605);
        checkOutput("bp2_bytes", {29'd0, out_bytes}, 32'd4);
        step(1);
        checkOutput("bp_words", words - word_base, 2);
        in_flush = 1'b1;
        step(1);
        in_flush = 1'b0;
        waitValid("bp3", 10);
        checkOutput("bp3_data", out_data, 32'h00000009);
        checkOutput("bp3_bytes", {29'd0, out_bytes}, 32'd1);
        checkOutput("bp_pops_all", pop_cnt - base, 9);
        step(2);

        // Idle timeout flush of two bytes
        $display("[TB] timeout");
        applyStimulus(8'hAA); applyStimulus(8'hBB);
        step(10);
        checkOutput("to_early", {31'd0, out_valid}, 32'd0);
        waitValid("to", 40);
        checkOutput("to_data", out_data, 32'h0000BBAA);
        checkOutput("to_bytes", {29'd0, out_bytes}, 32'd2);
        step(2);

        // Flush pulsed while the third byte is popped
        $display("[TB] flush with byte in flight");
        word_base = words;
        base = pop_cnt;
        applyStimulus(8'h31); applyStimulus(8'h32); applyStimulus(8'h33);
        for (int i = 0; i < 20; i++) begin
            if (fifo_read_ctrl && pop_cnt - base == 2) break;
            step(1);
        end
        checkOutput("fl_third_pop", {31'd0, fifo_read_ctrl}, 32'd1);
        in_flush = 1'b1;
        step(1);
        in_flush = 1'b0;
        waitValid("fl", 10);
        checkOutput("fl_data", out_data, 32'h00333231);
        checkOutput("fl_bytes", {29'd0, out_bytes}, 32'd3);
        step(25);
        checkOutput("fl_words", words - word_base, 1);

        // Flush with empty accumulator is ignored
        $display("[TB] flush when empty");
        word_base = words;
        in_flush = 1'b1;
        step(1);
        in_flush = 1'b0;
        step(20);
        checkOutput("fe_words", words - word_base, 0);
        checkOutput("fe_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(8'h5A); applyStimulus(8'h6B);
        applyStimulus(8'h7C); applyStimulus(8'h8D);
        waitValid("fe", 40);
        checkOutput("fe_data", out_data, 32'h8D7C6B5A);
        checkOutput("fe_bytes", {29'd0, out_bytes}, 32'd4);
        step(2);

        // Reset with a held word and three accumulated bytes
        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(8'hC1); applyStimulus(8'hC2);
        applyStimulus(8'hC3); applyStimulus(8'hC4);
        applyStimulus(8'hD1); applyStimulus(8'hD2); applyStimulus(8'hD3);
        step(20);
        checkOutput("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("mr_pre_data", out_data, 32'hC4C3C2C1);
        rst = 1'b1;
        step(1);
        checkOutput("mr_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mr_data", out_data, 32'd0);
        checkOutput("mr_bytes", {29'd0, out_bytes}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'hE1); applyStimulus(8'hE2);
        applyStimulus(8'hE3); applyStimulus(8'hE4);
        waitValid("mr", 40);
        checkOutput("mr_new_data", out_data, 32'hE4E3E2E1);
        checkOutput("mr_new_bytes", {29'd0, out_bytes}, 32'd4);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
